// File: rtl/nco_freq_meter_if.sv
// Sample-stream and result bundle between a waveform source (master) and
// the nco_freq_meter (slave). Clock and reset stay outside the bundle.
interface nco_freq_meter_if;
    logic       enable;
    logic       sample_valid;
    logic [7:0] sample;
    logic [7:0] freq_est;
    logic       freq_valid;
    logic       no_signal;
    logic       locked;

    modport master (
        output enable, sample_valid, sample,
        input  freq_est, freq_valid, no_signal, locked
    );

    modport slave (
        input  enable, sample_valid, sample,
        output freq_est, freq_valid, no_signal, locked
    );
endinterface

// File: rtl/nco_freq_meter.sv
// nco_freq_meter: recovers the phase increment of an 8-bit offset-binary
// sine stream. Rising midscale crossings (with hysteresis) bound a window
// of 2^PER_LOG2 periods; the sample count S over that window is turned into
// round(2^(8+PER_LOG2)/S) by a bit-serial restoring divider.
// Optional feature macro: NCO_FREQ_LOCK_EN (adds the 'locked' flag logic;
// without it 'locked' is tied low).
module nco_freq_meter #(
    parameter int HYST     = 8,
    parameter int PER_LOG2 = 2
) (
    input  logic            clk,
    input  logic            reset,
    nco_freq_meter_if.slave bus
);
    localparam int CNT_W = 10 + PER_LOG2;
    localparam int NUM_W = 10 + PER_LOG2;
    localparam int DC_W  = $clog2(NUM_W + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARM     = 3'd1;
    localparam logic [2:0] ST_SYNC    = 3'd2;
    localparam logic [2:0] ST_MEASURE = 3'd3;
    localparam logic [2:0] ST_DIVIDE  = 3'd4;

    localparam logic [1:0] LVL_UNKNOWN = 2'd0;
    localparam logic [1:0] LVL_LOW     = 2'd1;
    localparam logic [1:0] LVL_HIGH    = 2'd2;

    localparam logic [8:0]          HI_TH    = 9'(128 + HYST);
    localparam logic [8:0]          LO_TH    = 9'(128 - HYST);
    // Timeout fires on the valid sample that would bring scnt to all-ones
    localparam logic [CNT_W-1:0]    SCNT_TMO = CNT_W'((1 << CNT_W) - 2);
    localparam logic [PER_LOG2:0]   NPER     = (PER_LOG2 + 1)'(1 << PER_LOG2);
    localparam logic [NUM_W-1:0]    NUM_BASE = NUM_W'(1 << (8 + PER_LOG2));
    localparam logic [NUM_W-1:0]    Q_MAX    = NUM_W'(255);
    localparam logic [DC_W-1:0]     DC_LAST  = DC_W'(NUM_W);

    logic [2:0]          state_r;
    logic [1:0]          level_r;
    logic [CNT_W-1:0]    scnt_r;
    logic [PER_LOG2:0]   ccnt_r;
    logic [CNT_W-1:0]    div_r;
    logic [CNT_W-1:0]    rem_r;
    logic [NUM_W-1:0]    quo_r;
    logic [DC_W-1:0]     div_cnt_r;
    logic [7:0]          freq_est_r;
    logic                freq_valid_r;
    logic                no_signal_r;

    logic [1:0]          level_nxt_s;
    logic                rise_s;
    logic                tmo_s;
    logic [CNT_W-1:0]    scnt_inc_s;
    logic [PER_LOG2:0]   ccnt_inc_s;
    logic [NUM_W-1:0]    num_load_s;
    logic [CNT_W:0]      rem_sh_s;
    logic [CNT_W-1:0]    rem_nxt_s;
    logic                q_bit_s;
    logic [7:0]          q_final_s;

    assign scnt_inc_s = scnt_r + CNT_W'(1);
    assign ccnt_inc_s = ccnt_r + (PER_LOG2 + 1)'(1);
    // Numerator carries +S/2 so the truncating divide rounds to nearest
    assign num_load_s = NUM_BASE + {1'b0, scnt_inc_s[CNT_W-1:1]};

    // Hysteresis level tracker, rising-crossing and timeout detection
    always_comb begin
        level_nxt_s = level_r;
        if (bus.sample_valid && (state_r != ST_IDLE)) begin
            if ({1'b0, bus.sample} >= HI_TH) begin
                level_nxt_s = LVL_HIGH;
            end else if ({1'b0, bus.sample} < LO_TH) begin
                level_nxt_s = LVL_LOW;
            end else begin
                level_nxt_s = level_r;
            end
        end else begin
            level_nxt_s = level_r;
        end
        rise_s = (level_r == LVL_LOW) && (level_nxt_s == LVL_HIGH);
        tmo_s  = 1'b0;
        if ((state_r == ST_ARM) || (state_r == ST_SYNC) || (state_r == ST_MEASURE)) begin
            // A crossing on the same sample takes priority over the timeout
            tmo_s = bus.sample_valid && !rise_s && (scnt_r >= SCNT_TMO);
        end else begin
            tmo_s = 1'b0;
        end
    end

    // One restoring-division step plus the saturating result clamp
    always_comb begin
        rem_sh_s = {rem_r, quo_r[NUM_W-1]};
        if (rem_sh_s >= {1'b0, div_r}) begin
            q_bit_s   = 1'b1;
            rem_nxt_s = CNT_W'(rem_sh_s - {1'b0, div_r});
        end else begin
            q_bit_s   = 1'b0;
            rem_nxt_s = rem_sh_s[CNT_W-1:0];
        end
        if (quo_r > Q_MAX) begin
            q_final_s = 8'hFF;
        end else begin
            q_final_s = quo_r[7:0];
        end
    end

    // Measurement FSM, counters, divider state and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            level_r      <= LVL_UNKNOWN;
            scnt_r       <= '0;
            ccnt_r       <= '0;
            div_r        <= '0;
            rem_r        <= '0;
            quo_r        <= '0;
            div_cnt_r    <= '0;
            freq_est_r   <= 8'h00;
            freq_valid_r <= 1'b0;
            no_signal_r  <= 1'b0;
        end else if (!bus.enable) begin
            state_r      <= ST_IDLE;
            level_r      <= LVL_UNKNOWN;
            scnt_r       <= '0;
            ccnt_r       <= '0;
            div_cnt_r    <= '0;
            freq_valid_r <= 1'b0;
            no_signal_r  <= 1'b0;
        end else begin
            freq_valid_r <= 1'b0;
            no_signal_r  <= 1'b0;
            level_r      <= level_nxt_s;
            if (tmo_s) begin
                freq_est_r   <= 8'h00;
                freq_valid_r <= 1'b1;
                no_signal_r  <= 1'b1;
                level_r      <= LVL_UNKNOWN;
                scnt_r       <= '0;
                ccnt_r       <= '0;
                state_r      <= ST_ARM;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        scnt_r  <= '0;
                        state_r <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (bus.sample_valid) begin
                            scnt_r <= scnt_inc_s;
                            if (level_nxt_s != LVL_UNKNOWN) begin
                                state_r <= ST_SYNC;
                            end
                        end
                    end
                    ST_SYNC: begin
                        if (bus.sample_valid) begin
                            if (rise_s) begin
                                scnt_r  <= '0;
                                ccnt_r  <= '0;
                                state_r <= ST_MEASURE;
                            end else begin
                                scnt_r <= scnt_inc_s;
                            end
                        end
                    end
                    ST_MEASURE: begin
                        if (bus.sample_valid) begin
                            scnt_r <= scnt_inc_s;
                            if (rise_s) begin
                                if (ccnt_inc_s == NPER) begin
                                    div_r     <= scnt_inc_s;
                                    quo_r     <= num_load_s;
                                    rem_r     <= '0;
                                    div_cnt_r <= '0;
                                    state_r   <= ST_DIVIDE;
                                end else begin
                                    ccnt_r <= ccnt_inc_s;
                                end
                            end
                        end
                    end
                    ST_DIVIDE: begin
                        if (div_cnt_r != DC_LAST) begin
                            rem_r     <= rem_nxt_s;
                            quo_r     <= {quo_r[NUM_W-2:0], q_bit_s};
                            div_cnt_r <= div_cnt_r + DC_W'(1);
                        end else begin
                            freq_est_r   <= q_final_s;
                            freq_valid_r <= 1'b1;
                            scnt_r       <= '0;
                            state_r      <= ST_SYNC;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.freq_est   = freq_est_r;
    assign bus.freq_valid = freq_valid_r;
    assign bus.no_signal  = no_signal_r;

`ifdef NCO_FREQ_LOCK_EN
    logic [7:0] prev_q_r;
    logic       prev_ok_r;
    logic       locked_r;
    logic [7:0] q_diff_s;
    logic       div_done_s;

    // Result-complete strobe and distance to the previous result
    always_comb begin
        div_done_s = (state_r == ST_DIVIDE) && (div_cnt_r == DC_LAST);
        if (q_final_s >= prev_q_r) begin
            q_diff_s = q_final_s - prev_q_r;
        end else begin
            q_diff_s = prev_q_r - q_final_s;
        end
    end

    // Lock flag: two consecutive good results within one LSB of each other
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q_r  <= 8'h00;
            prev_ok_r <= 1'b0;
            locked_r  <= 1'b0;
        end else if (!bus.enable || tmo_s) begin
            prev_ok_r <= 1'b0;
            locked_r  <= 1'b0;
        end else if (div_done_s) begin
            prev_q_r  <= q_final_s;
            prev_ok_r <= 1'b1;
            locked_r  <= prev_ok_r && (q_diff_s <= 8'd1);
        end
    end

    assign bus.locked = locked_r;
`else
    assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_nco_freq_meter.sv
// Self-checking bench for nco_freq_meter: an 8-bit sine NCO feeds the meter;
// a reference model tracks hysteresis crossings on the driven samples and
// computes the expected estimate from the sample count between crossings.
module tb_nco_freq_meter;
    localparam int HYST     = 8;
    localparam int PER_LOG2 = 2;
    localparam int NPER     = 1 << PER_LOG2;
    localparam int NUMB     = 1 << (8 + PER_LOG2);
    localparam int LAT      = 11 + PER_LOG2;
    localparam int TMO_N    = (1 << (10 + PER_LOG2)) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nco_freq_meter_if bus ();

    nco_freq_meter #(.HYST(HYST), .PER_LOG2(PER_LOG2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int         lut [256];
    logic [7:0] phase;
    int         phaseinc;
    int         duty;
    bit         dc_mode;
    bit         exp_tmo;

    int cyc    = 0;
    int vcount = 0;
    int mlevel = 0;
    int cross_cyc [$];
    int cross_vc  [$];
    int pulse_cyc [$];
    int n_res  = 0;
    int exp_q  = 0;
    bit prev_ok = 1'b0;
`ifdef NCO_FREQ_LOCK_EN
    int prev_q = 0;
`endif

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: model consumes the inputs of this edge, outputs are checked, next inputs driven
    task automatic step();
        int nl;
        int idx;
        int s;
        int q;
        @(posedge clk);
        #1;
        cyc++;
        if (reset || !bus.enable) begin
            mlevel = 0;
            cross_cyc.delete();
            cross_vc.delete();
            prev_ok = 1'b0;
            if (reset) exp_q = 0;
        end else if (bus.sample_valid) begin
            vcount++;
            nl = mlevel;
            if (int'(bus.sample) >= 128 + HYST) nl = 2;
            else if (int'(bus.sample) < 128 - HYST) nl = 1;
            if (mlevel == 1 && nl == 2) begin
                cross_cyc.push_back(cyc);
                cross_vc.push_back(vcount);
            end
            mlevel = nl;
        end

        if (bus.freq_valid === 1'b1) begin
            n_res++;
            pulse_cyc.push_back(cyc);
            check_value("no_signal", bus.no_signal, exp_tmo);
            if (exp_tmo) begin
                check_value("tmo_est", bus.freq_est, 0);
                check_value("tmo_locked", bus.locked, 0);
                exp_q   = 0;
                prev_ok = 1'b0;
                mlevel  = 0;
            end else begin
                idx = -1;
                foreach (cross_cyc[i]) if (cross_cyc[i] == cyc - LAT) idx = i;
                check_value("latency", (idx >= 0), 1);
                check_value("window", (idx >= NPER), 1);
                q = 0;
                if (idx >= NPER) begin
                    s = cross_vc[idx] - cross_vc[idx - NPER];
                    q = (NUMB + s / 2) / s;
                    if (q > 255) q = 255;
                    check_value("freq_est", bus.freq_est, q);
                end
                exp_q = q;
`ifdef NCO_FREQ_LOCK_EN
                check_value("locked", bus.locked, (prev_ok && (q - prev_q <= 1) && (prev_q - q <= 1)));
                prev_q  = q;
                prev_ok = 1'b1;
`else
                check_value("locked", bus.locked, 0);
`endif
            end
        end else begin
            check_value("no_signal_idle", bus.no_signal, 0);
        end

        if (dc_mode) begin
            bus.sample       = 8'h80;
            bus.sample_valid = 1'b1;
        end else begin
            bus.sample_valid = ($urandom_range(99) < duty);
            bus.sample       = 8'(lut[phase]);
            if (bus.sample_valid) phase = phase + 8'(phaseinc);
        end
    endtask

    // Abort via enable, confirm the estimate is held, then start a new tone
    task automatic restart(input int pinc, input int pduty, input bit dc);
        bus.enable = 1'b0;
        step();
        step();
        check_value("hold_est", bus.freq_est, exp_q);
        check_value("hold_valid", bus.freq_valid, 0);
        phaseinc         = pinc;
        duty             = pduty;
        dc_mode          = dc;
        exp_tmo          = dc;
        phase            = 8'h00;
        bus.sample       = 8'h80;
        bus.sample_valid = 1'b0;
        bus.enable       = 1'b1;
    endtask

    task automatic run_results(input int n, input int budget);
        int start;
        int k;
        start = n_res;
        k = 0;
        while (n_res < start + n && k < budget) begin
            step();
            k++;
        end
        check_value("results_seen", n_res - start, n);
    endtask

    initial begin
        int d;
        int target;
        int n0;
        int e_cyc;
        for (int i = 0; i < 256; i++)
            lut[i] = 128 + int'(127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0));
        phase            = 8'h00;
        phaseinc         = 1;
        duty             = 100;
        dc_mode          = 1'b0;
        exp_tmo          = 1'b0;
        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = 8'h80;
        repeat (3) step();
        check_value("rst_est", bus.freq_est, 0);
        check_value("rst_valid", bus.freq_valid, 0);
        check_value("rst_nosig", bus.no_signal, 0);
        check_value("rst_locked", bus.locked, 0);
        reset = 1'b0;

        // Slowest tone: 256 samples per period, S = 1024
        restart(1, 100, 1'b0);
        run_results(2, 4000);
        check_value("p01_est", bus.freq_est, 1);

        // Exact-period tone, repeated results
        restart(16, 100, 1'b0);
        run_results(3, 2000);
        check_value("p10_est", bus.freq_est, 16);

        // Fractional period with 50% sample_valid duty
        restart(3, 50, 1'b0);
        run_results(2, 4000);
        check_value("p03_est", bus.freq_est, 3);

        // Reset in the middle of a divide: no pulse, estimate cleared, then recovers
        restart(16, 100, 1'b0);
        run_results(3, 2000);
        d      = pulse_cyc[$] - pulse_cyc[$-1];
        target = pulse_cyc[$] + d - 5;
        while (cyc < target - 1) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_value("rstdiv_est", bus.freq_est, 0);
        check_value("rstdiv_valid", bus.freq_valid, 0);
        n0 = n_res;
        repeat (20) step();
        check_value("rstdiv_nopulse", n_res - n0, 0);
        run_results(1, 2000);
        check_value("rstdiv_recover", bus.freq_est, 16);

        // Randomized tones and duty cycles against the reference model
        for (int t = 0; t < 4; t++) begin
            restart($urandom_range(64, 2), $urandom_range(100, 40), 1'b0);
            run_results(2, 6000);
        end

        // DC at midscale: timeout after 4095 valid samples, then again
        restart(1, 100, 1'b1);
        e_cyc = cyc + 1;
        run_results(2, 9000);
        if (pulse_cyc.size() >= 2) begin
            check_value("tmo_first", pulse_cyc[$-1] - e_cyc, TMO_N);
            check_value("tmo_period", pulse_cyc[$] - pulse_cyc[$-1], TMO_N);
        end else begin
            check_value("tmo_pulses", pulse_cyc.size(), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
